// File: rtl/bus_interconnect_n.sv
// Registered single-master to NUM_SLAVES interconnect with one-hot slave select and ack/err return.
// Optional slave timeout abort is enabled by defining BUS_TIMEOUT_EN.
module bus_interconnect_n #(
    parameter int NUM_SLAVES = 8,
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int SW         = 4,
    parameter int SLAVE_BITS = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m_stb_i,
    input  logic [AW-1:0]            m_addr_i,
    input  logic [DW-1:0]            m_data_i,
    input  logic                     m_we_i,
    input  logic [SW-1:0]            m_select_i,
    output logic [DW-1:0]            m_data_o,
    output logic                     m_ack_o,
    output logic                     m_err_o,
    output logic                     busy_o,
    output logic [AW-1:0]            s_addr_o,
    output logic [DW-1:0]            s_data_o,
    output logic                     s_we_o,
    output logic [SW-1:0]            s_be_o,
    output logic [NUM_SLAVES-1:0]    s_select_o,
    input  logic [NUM_SLAVES*DW-1:0] s_data_i,
    input  logic [NUM_SLAVES-1:0]    s_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [AW-1:0]           s_addr_q, s_addr_d;
    logic [DW-1:0]           s_data_q, s_data_d;
    logic                    s_we_q, s_we_d;
    logic [SW-1:0]           s_be_q, s_be_d;
    logic [NUM_SLAVES-1:0]   s_select_q, s_select_d;
    logic                    err_q, err_d;
    logic [DW-1:0]           rdata_q, rdata_d;

    logic [SLAVE_BITS-1:0]   req_idx;
    logic                    req_mapped;
    logic                    sel_ack;
    logic [DW-1:0]           sel_data;
    logic                    timeout;

    assign req_idx    = m_addr_i[AW-1 -: SLAVE_BITS];
    assign req_mapped = 32'(req_idx) < 32'(NUM_SLAVES);

    // The one-hot select doubles as the return mux control, so stray acks fall out naturally.
    assign sel_ack = |(s_ack_i & s_select_q);

    // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (s_select_q[i]) begin
                sel_data = s_data_i[i*DW +: DW];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign timeout = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (state_q == ST_WAIT && !sel_ack && !timeout) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // FSM state register
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (m_stb_i) begin
                    state_d = req_mapped ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (sel_ack || timeout) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values; an ack in the terminal-count cycle takes priority over the abort.
    always_comb begin
        s_addr_d   = s_addr_q;
        s_data_d   = s_data_q;
        s_we_d     = s_we_q;
        s_be_d     = s_be_q;
        s_select_d = s_select_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (m_stb_i) begin
                    s_addr_d   = m_addr_i;
                    s_data_d   = m_data_i;
                    s_we_d     = m_we_i;
                    s_be_d     = m_select_i;
                    s_select_d = req_mapped ? (NUM_SLAVES'(1) << req_idx) : '0;
                    err_d      = !req_mapped;
                    rdata_d    = '0;
                end
            end
            ST_WAIT: begin
                if (sel_ack) begin
                    s_select_d = '0;
                    err_d      = 1'b0;
                    rdata_d    = s_we_q ? '0 : sel_data;
                end else if (timeout) begin
                    s_select_d = '0;
                    err_d      = 1'b1;
                    rdata_d    = '0;
                end
            end
            default: ;
        endcase
    end

    // NOTE: every register here is small control/datapath state, so all of it is reset to a known 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_addr_q   <= '0;
            s_data_q   <= '0;
            s_we_q     <= 1'b0;
            s_be_q     <= '0;
            s_select_q <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            s_addr_q   <= s_addr_d;
            s_data_q   <= s_data_d;
            s_we_q     <= s_we_d;
            s_be_q     <= s_be_d;
            s_select_q <= s_select_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    // FSM outputs: the master response is only visible during RESP.
    always_comb begin
        busy_o   = (state_q != ST_IDLE);
        m_ack_o  = (state_q == ST_RESP);
        m_err_o  = (state_q == ST_RESP) && err_q;
        m_data_o = (state_q == ST_RESP) ? rdata_q : '0;
    end

    assign s_addr_o   = s_addr_q;
    assign s_data_o   = s_data_q;
    assign s_we_o     = s_we_q;
    assign s_be_o     = s_be_q;
    assign s_select_o = s_select_q;

endmodule

// File: tb/tb_bus_interconnect_n.sv
// Randomized transaction-level bench for bus_interconnect_n against a behavioural response model.
// Covers both builds: with BUS_TIMEOUT_EN a stalled slave must abort, without it the bus must stay busy.
module tb_bus_interconnect_n;

    localparam int NS = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 4;
`ifdef BUS_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              m_stb_i;
    logic [AW-1:0]     m_addr_i;
    logic [DW-1:0]     m_data_i;
    logic              m_we_i;
    logic [SW-1:0]     m_select_i;
    logic [DW-1:0]     m_data_o;
    logic              m_ack_o;
    logic              m_err_o;
    logic              busy_o;
    logic [AW-1:0]     s_addr_o;
    logic [DW-1:0]     s_data_o;
    logic              s_we_o;
    logic [SW-1:0]     s_be_o;
    logic [NS-1:0]     s_select_o;
    logic [NS*DW-1:0]  s_data_i;
    logic [NS-1:0]     s_ack_i;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] slave_rd [NS];

    bus_interconnect_n #(
        .NUM_SLAVES (NS),
        .AW         (AW),
        .DW         (DW),
        .SW         (SW),
        .SLAVE_BITS (4),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m_stb_i    (m_stb_i),
        .m_addr_i   (m_addr_i),
        .m_data_i   (m_data_i),
        .m_we_i     (m_we_i),
        .m_select_i (m_select_i),
        .m_data_o   (m_data_o),
        .m_ack_o    (m_ack_o),
        .m_err_o    (m_err_o),
        .busy_o     (busy_o),
        .s_addr_o   (s_addr_o),
        .s_data_o   (s_data_o),
        .s_we_o     (s_we_o),
        .s_be_o     (s_be_o),
        .s_select_o (s_select_o),
        .s_data_i   (s_data_i),
        .s_ack_i    (s_ack_i)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=no_finish exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_ack"},  m_ack_o,    0);
        check({tag, "_m_err"},  m_err_o,    0);
        check({tag, "_m_data"}, m_data_o,   0);
        check({tag, "_busy"},   busy_o,     0);
        check({tag, "_s_addr"}, s_addr_o,   0);
        check({tag, "_s_data"}, s_data_o,   0);
        check({tag, "_s_we"},   s_we_o,     0);
        check({tag, "_s_be"},   s_be_o,     0);
        check({tag, "_s_sel"},  s_select_o, 0);
    endtask

    task automatic drive_slaves();
        for (int i = 0; i < NS; i++) begin
            s_data_i[i*DW +: DW] = slave_rd[i];
        end
    endtask

    // Called just after a rising edge with the bus idle; returns just after the edge following RESP.
    // wait_n is the number of wait states the addressed slave inserts before acking.
    task automatic run_txn(input string tag, input logic [AW-1:0] addr, input logic we,
                           input logic [DW-1:0] wdata, input logic [SW-1:0] be,
                           input int wait_n, input bit stray);
        int            idx;
        bit            mapped;
        bit            exp_err;
        logic [DW-1:0] exp_data;
        int            exp_wait;
        int            n_wait;
        int            side_bad;

        idx    = int'(addr[AW-1 -: 4]);
        mapped = (idx < NS);
        if (!mapped) begin
            exp_err  = 1'b1;
            exp_data = '0;
            exp_wait = 0;
        end else if (TO_ON && wait_n >= TO) begin
            exp_err  = 1'b1;
            exp_data = '0;
            exp_wait = TO;
        end else begin
            exp_err  = 1'b0;
            exp_data = we ? '0 : slave_rd[idx];
            exp_wait = wait_n + 1;
        end

        drive_slaves();
        s_ack_i    = '0;
        m_stb_i    = 1'b1;
        m_addr_i   = addr;
        m_data_i   = wdata;
        m_we_i     = we;
        m_select_i = be;
        @(posedge clk); #1;

        n_wait   = 0;
        side_bad = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (m_ack_o) break;
            n_wait++;
            if (!busy_o || m_err_o || m_data_o != '0) side_bad++;
            if (s_select_o != (mapped ? (NS'(1) << idx) : NS'(0))) side_bad++;
            s_ack_i = '0;
            if (mapped && n_wait == wait_n + 1) begin
                s_ack_i[idx] = 1'b1;
            end else if (mapped && stray) begin
                s_ack_i[(idx + 1 + int'($urandom_range(0, NS - 2))) % NS] = 1'b1;
            end
            @(posedge clk); #1;
        end
        s_ack_i = '0;

        check({tag, "_ack_seen"},  m_ack_o,    1);
        check({tag, "_wait_cyc"},  n_wait,     exp_wait);
        check({tag, "_wait_bad"},  side_bad,   0);
        check({tag, "_err"},       m_err_o,    exp_err);
        check({tag, "_rdata"},     m_data_o,   exp_data);
        check({tag, "_busy_resp"}, busy_o,     1);
        check({tag, "_sel_resp"},  s_select_o, 0);
        check({tag, "_s_addr"},    s_addr_o,   addr);
        check({tag, "_s_data"},    s_data_o,   wdata);
        check({tag, "_s_we"},      s_we_o,     we);
        check({tag, "_s_be"},      s_be_o,     be);

        m_stb_i = 1'b0;
        @(posedge clk); #1;
        check({tag, "_ack_pulse"}, m_ack_o, 0);
        check({tag, "_idle"},      busy_o,  0);
    endtask

    initial begin
        int stall_bad;

        rst        = 1'b0;
        m_stb_i    = 1'b0;
        m_addr_i   = '0;
        m_data_i   = '0;
        m_we_i     = 1'b0;
        m_select_i = '0;
        s_ack_i    = '0;
        for (int i = 0; i < NS; i++) slave_rd[i] = $urandom;
        drive_slaves();

        #12;
        check_all_zero("reset");
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        slave_rd[2] = 32'hDEAD_BEEF;
        run_txn("rd_s2_zw", 32'h2000_0010, 1'b0, 32'h0, 4'hF, 0, 1'b0);
        run_txn("wr_s6_3ws", 32'h6000_0040, 1'b1, 32'h0000_00A5, 4'h1, 3, 1'b0);
        run_txn("unmapped", 32'h9000_0000, 1'b0, 32'h1234_5678, 4'hF, 0, 1'b0);
        run_txn("stray_s1", 32'h1000_0008, 1'b0, 32'h0, 4'h3, 2, 1'b1);
        run_txn("edge_to", 32'h5000_0000, 1'b0, 32'h0, 4'hF, TO - 1, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            logic [AW-1:0] addr;
            for (int i = 0; i < NS; i++) slave_rd[i] = $urandom;
            addr = $urandom;
            if ($urandom_range(0, 9) < 7) addr[AW-1 -: 4] = 4'($urandom_range(0, NS - 1));
            run_txn("rand", addr, 1'($urandom), $urandom, 4'($urandom),
                    int'($urandom_range(0, TO_ON ? TO + 1 : 5)), 1'($urandom));
        end

        // Stalled slave 3
`ifdef BUS_TIMEOUT_EN
        run_txn("stall_to", 32'h3000_0000, 1'b0, 32'h0, 4'hF, 1000, 1'b0);
`else
        m_stb_i    = 1'b1;
        m_addr_i   = 32'h3000_0000;
        m_we_i     = 1'b0;
        m_select_i = 4'hF;
        s_ack_i    = '0;
        @(posedge clk); #1;
        stall_bad = 0;
        for (int c = 0; c < 120; c++) begin
            if (!busy_o || s_select_o != NS'(8'h08) || m_ack_o) stall_bad++;
            @(posedge clk); #1;
        end
        check("stall_busy", stall_bad, 0);
        rst = 1'b0;
        #1;
        check_all_zero("stall_rst");
        m_stb_i = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
`endif

        // Reset asserted mid-WAIT on slave 0
        m_stb_i    = 1'b1;
        m_addr_i   = 32'h0000_0100;
        m_we_i     = 1'b0;
        m_data_i   = 32'hCAFE_0000;
        m_select_i = 4'hF;
        s_ack_i    = '0;
        @(posedge clk); #1;
        check("rstmid_sel", s_select_o, 1);
        @(posedge clk); #1;
        #2 rst = 1'b0;
        #1;
        check_all_zero("rstmid");
        m_stb_i = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        slave_rd[0] = 32'h0BAD_F00D;
        run_txn("post_rst_s0", 32'h0000_0200, 1'b0, 32'h0, 4'hF, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
